// File: rtl/axis2fifo_pkg.sv
// Shared definitions for the AXIS-to-FIFO write bridge: state encoding and
// the all-ones helper used for the saturating beat counter.
package axis2fifo_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [63:0] all_ones(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/axis2fifo_wcnt.sv
// Saturating beat counter for axis2fifo: steps on every accepted beat, clears
// at end of frame, and keeps a sticky flag once a frame runs past full scale.
module axis2fifo_wcnt
  import axis2fifo_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_next_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] CNT_MAX = W'(all_ones(W));

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         at_max;

  assign at_max     = (cnt_q == CNT_MAX);
  assign cnt_next_o = at_max ? CNT_MAX : cnt_q + W'(1);
  assign ovf_o      = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (step_i) begin
      // stepping from full scale means this frame no longer fits the counter
      ovf_d = ovf_q | at_max;
      cnt_d = clr_i ? '0 : cnt_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: rtl/axis2fifo.sv
// AXI-Stream slave to FIFO write-port bridge with per-frame beat counting.
// Define AXIS2FIFO_FRAME_STOP_EN to capture one frame per enable pulse.
module axis2fifo
  import axis2fifo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int AXIS_LEN_W = 16
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  axis_tvalid_i,
  input  logic [DATA_W-1:0]     axis_tdata_i,
  input  logic                  axis_tlast_i,
  output logic                  axis_tready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_write_o,
  output logic [DATA_W-1:0]     fifo_wdata_o,
  output logic [AXIS_LEN_W-1:0] len_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  state_e                state_q;
  logic                  accept;
  logic                  accept_last;
  logic [AXIS_LEN_W-1:0] cnt_next;
  logic [AXIS_LEN_W-1:0] len_q, len_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  assign axis_tready_o = cke_i & en_i & ~fifo_full_i & (state_q == ST_RUN);
  assign accept        = axis_tvalid_i & axis_tready_o;
  assign accept_last   = accept & axis_tlast_i;
  assign fifo_write_o  = accept;
  assign fifo_wdata_o  = axis_tdata_i;

  axis2fifo_wcnt #(.W(AXIS_LEN_W)) u_wcnt (
    .clk_i      (clk_i),
    .cke_i      (cke_i),
    .rst_i      (rst_i),
    .step_i     (accept),
    .clr_i      (accept_last),
    .cnt_next_o (cnt_next),
    .ovf_o      (overflow_o)
  );

  always_comb begin
    len_d  = len_q;
    done_d = accept_last;
    busy_d = busy_q;
    if (accept) begin
      busy_d = ~axis_tlast_i;
      if (axis_tlast_i) len_d = cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        len_q  <= '0;
        done_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        len_q  <= len_d;
        done_q <= done_d;
        busy_q <= busy_d;
      end
    end
  end

`ifdef AXIS2FIFO_FRAME_STOP_EN
  state_e state_d;

  // a captured frame parks the bridge until software drops en_i for a cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept_last) state_d = ST_HOLD;
      ST_HOLD: if (!en_i)       state_d = ST_RUN;
      default:                  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) state_q <= ST_RUN;
      else       state_q <= state_d;
    end
  end
`else
  assign state_q = ST_RUN;
`endif

  assign len_o  = len_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule
